// File: rtl/scu_pkg.sv
// rtl/scu_pkg.sv - shared state and mode encodings for the signal control unit
package scu_pkg;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ARMED    = 3'd1,
        DELAY    = 3'd2,
        ACTIVE   = 3'd3,
        DONE     = 3'd4
    } scu_state_e;

    typedef enum logic [1:0] {
        FORCE     = 2'd0,
        INVERT    = 2'd1,
        HOLD      = 2'd2,
        FORCE_ALT = 2'd3
    } scu_mode_e;

endpackage

// File: rtl/scu_down_counter.sv
// rtl/scu_down_counter.sv - loadable down counter that parks at 1 and never wraps
module scu_down_counter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          is_one_o,
    output logic          is_zero_o
);

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] cnt_q;

    // Load wins over decrement; decrement stops at 1 so a loaded 0 stays 0 (sticky).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q > ONE)) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign is_one_o  = (cnt_q == ONE);
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/scu_unit.sv
// rtl/scu_unit.sv - inline signal override unit driven by an SMU trigger
module scu_unit
    import scu_pkg::*;
#(
    parameter int C  = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [C-1:0]  s_in,
    output logic [C-1:0]  s_out,
    input  logic          trigger,
    input  logic          ScuEn,
    input  logic [C-1:0]  RegCtrlMask,
    input  logic [C-1:0]  RegCtrlVal,
    input  logic [1:0]    RegCtrlMode,
    input  logic [DW-1:0] RegDelay,
    input  logic [DW-1:0] RegDuration,
    input  logic          RegRearm,
    output logic [2:0]    ScuState,
    output logic          ScuActive,
    output logic [CW-1:0] ScuFireCnt
);

    scu_state_e    state_q, state_d;
    scu_mode_e     mode_q;
    logic [C-1:0]  held_q;
    logic [CW-1:0] fire_cnt_q;
    logic [C-1:0]  ovr;

    logic enter_active;
    logic dly_load, dly_dec, dly_is_one, dly_is_zero;
    logic dur_dec, dur_is_one, dur_is_zero;

    scu_down_counter #(.DW(DW)) u_delay_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dly_load),
        .load_val_i (RegDelay),
        .dec_i      (dly_dec),
        .is_one_o   (dly_is_one),
        .is_zero_o  (dly_is_zero)
    );

    scu_down_counter #(.DW(DW)) u_duration_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (enter_active),
        .load_val_i (RegDuration),
        .dec_i      (dur_dec),
        .is_one_o   (dur_is_one),
        .is_zero_o  (dur_is_zero)
    );

    // Next state and counter control; losing the enable overrides everything else.
    always_comb begin
        state_d      = state_q;
        enter_active = 1'b0;
        dly_load     = 1'b0;
        dly_dec      = 1'b0;
        dur_dec      = 1'b0;
        if (!ScuEn) begin
            state_d = DISABLED;
        end else begin
            case (state_q)
                DISABLED: state_d = ARMED;
                ARMED: begin
                    if (trigger) begin
                        if (RegDelay == '0) begin
                            state_d      = ACTIVE;
                            enter_active = 1'b1;
                        end else begin
                            state_d  = DELAY;
                            dly_load = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    // A delay counter of zero is unreachable here; treat it like the last cycle.
                    if (dly_is_one || dly_is_zero) begin
                        state_d      = ACTIVE;
                        enter_active = 1'b1;
                    end else begin
                        dly_dec = 1'b1;
                    end
                end
                ACTIVE: begin
                    // A zero duration counter means the override is sticky.
                    if (!dur_is_zero) begin
                        if (dur_is_one) begin
                            state_d = RegRearm ? ARMED : DONE;
                        end else begin
                            dur_dec = 1'b1;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = DISABLED;
            endcase
        end
    end

    // State register plus the snapshot taken on every ACTIVE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DISABLED;
            mode_q     <= FORCE;
            held_q     <= '0;
            fire_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (enter_active) begin
                held_q <= s_in;
                mode_q <= scu_mode_e'(RegCtrlMode);
                if (fire_cnt_q != '1) begin
                    fire_cnt_q <= fire_cnt_q + CW'(1);
                end
            end
        end
    end

    // Override value selected by the mode captured at ACTIVE entry.
    always_comb begin
        case (mode_q)
            INVERT:  ovr = ~s_in;
            HOLD:    ovr = held_q;
            default: ovr = RegCtrlVal;
        endcase
    end

    assign ScuActive  = (state_q == ACTIVE) && ScuEn;
    assign s_out      = ScuActive ? ((RegCtrlMask & ovr) | (~RegCtrlMask & s_in)) : s_in;
    assign ScuState   = state_q;
    assign ScuFireCnt = fire_cnt_q;

endmodule

// File: tb/tb_scu_unit.sv
// tb/tb_scu_unit.sv - directed self-checking bench for scu_unit with a cycle model
module tb_scu_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] s_in = 4'b1010;
    logic [3:0] s_out;
    logic       trigger = 1'b0;
    logic       ScuEn = 1'b0;
    logic [3:0] RegCtrlMask = 4'b0000;
    logic [3:0] RegCtrlVal = 4'b0000;
    logic [1:0] RegCtrlMode = 2'b00;
    logic [7:0] RegDelay = 8'd0;
    logic [7:0] RegDuration = 8'd0;
    logic       RegRearm = 1'b0;
    logic [2:0] ScuState;
    logic       ScuActive;
    logic [7:0] ScuFireCnt;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_on = 1'b0;

    scu_unit dut (
        .clk         (clk),
        .rst         (rst),
        .s_in        (s_in),
        .s_out       (s_out),
        .trigger     (trigger),
        .ScuEn       (ScuEn),
        .RegCtrlMask (RegCtrlMask),
        .RegCtrlVal  (RegCtrlVal),
        .RegCtrlMode (RegCtrlMode),
        .RegDelay    (RegDelay),
        .RegDuration (RegDuration),
        .RegRearm    (RegRearm),
        .ScuState    (ScuState),
        .ScuActive   (ScuActive),
        .ScuFireCnt  (ScuFireCnt)
    );

    always #5 clk = ~clk;

    // Model: phase number (0 off, 1 waiting, 2 delaying, 3 overriding, 4 finished)
    // and cycles remaining in the current phase; sticky when the captured length is 0.
    int         m_phase = 0;
    int         m_left = 0;
    int         m_len = 0;
    int         m_fire = 0;
    logic [3:0] m_held = 4'b0000;
    logic [1:0] m_mode = 2'b00;

    task automatic model_fire();
        m_phase = 3;
        m_len   = int'(RegDuration);
        m_left  = m_len;
        m_held  = s_in;
        m_mode  = RegCtrlMode;
        m_fire  = (m_fire < 255) ? m_fire + 1 : 255;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_left = 0; m_len = 0; m_fire = 0; m_held = 4'b0000; m_mode = 2'b00;
        end else if (!ScuEn) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (trigger) begin
                       if (RegDelay == 8'd0) model_fire();
                       else begin m_phase = 2; m_left = int'(RegDelay); end
                   end
                2: begin
                       m_left = m_left - 1;
                       if (m_left == 0) model_fire();
                   end
                3: if (m_len != 0) begin
                       m_left = m_left - 1;
                       if (m_left == 0) m_phase = RegRearm ? 1 : 4;
                   end
                default: m_phase = 4;
            endcase
        end
    end

    function automatic logic [3:0] model_sout();
        logic [3:0] r;
        r = s_in;
        if (m_phase == 3 && ScuEn) begin
            for (int b = 0; b < 4; b++) begin
                if (RegCtrlMask[b]) begin
                    case (m_mode)
                        2'b01:   r[b] = ~s_in[b];
                        2'b10:   r[b] = m_held[b];
                        default: r[b] = RegCtrlVal[b];
                    endcase
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Continuous comparison against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_s_out", 32'(s_out), 32'(model_sout()));
            chk("cyc_state", 32'(ScuState), 32'(m_phase));
            chk("cyc_active", 32'(ScuActive), 32'(m_phase == 3 && ScuEn));
            chk("cyc_fire", 32'(ScuFireCnt), 32'(m_fire));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reenable();
        ScuEn = 1'b0; tick();
        ScuEn = 1'b1; tick();
    endtask

    initial begin
        // Reset
        tick();
        #1;
        chk("rst_s_out", 32'(s_out), 32'(4'b1010));
        chk("rst_state", 32'(ScuState), 32'd0);
        chk("rst_fire", 32'(ScuFireCnt), 32'd0);
        cmp_on = 1'b1;
        rst = 1'b0; ScuEn = 1'b1;
        tick(); #1;
        chk("rst_armed", 32'(ScuState), 32'd1);

        // Force mode, one-shot, duration 3
        RegCtrlMask = 4'b0011; RegCtrlVal = 4'b0001; RegCtrlMode = 2'b00;
        RegDelay = 8'd0; RegDuration = 8'd3; RegRearm = 1'b0; s_in = 4'b1110;
        trigger = 1'b1; tick(); trigger = 1'b0; #1;
        chk("force_t1", 32'(s_out), 32'(4'b1101));
        tick(); #1; chk("force_t2", 32'(s_out), 32'(4'b1101));
        tick(); #1; chk("force_t3", 32'(s_out), 32'(4'b1101));
        tick(); #1; chk("force_t4", 32'(s_out), 32'(4'b1110));
        chk("force_done", 32'(ScuState), 32'd4);
        chk("force_fire", 32'(ScuFireCnt), 32'd1);
        chk("model_fire1", 32'(m_fire), 32'd1);
        reenable();

        // Invert mode, delay 2, duration 1; trigger held into t+1 must be ignored
        RegCtrlMask = 4'b1111; RegCtrlMode = 2'b01; RegDelay = 8'd2; RegDuration = 8'd1;
        s_in = 4'b1010;
        trigger = 1'b1; tick(); #1;
        chk("inv_dly_t1", 32'(ScuState), 32'd2);
        chk("inv_pass_t1", 32'(s_out), 32'(4'b1010));
        tick(); trigger = 1'b0; #1;
        chk("inv_dly_t2", 32'(ScuState), 32'd2);
        tick(); #1;
        chk("inv_t3", 32'(s_out), 32'(4'b0101));
        tick(); #1;
        chk("inv_t4", 32'(s_out), 32'(4'b1010));
        chk("inv_done", 32'(ScuState), 32'd4);
        reenable();

        // Hold mode, sticky
        RegCtrlMode = 2'b10; RegDelay = 8'd0; RegDuration = 8'd0; s_in = 4'b0110;
        trigger = 1'b1; tick(); trigger = 1'b0; s_in = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1; chk("hold_s_out", 32'(s_out), 32'(4'b0110));
            tick();
        end
        chk("hold_state", 32'(ScuState), 32'd3);
        ScuEn = 1'b0; #1;
        chk("hold_en_off", 32'(s_out), 32'(4'b1001));
        tick(); #1;
        chk("hold_disabled", 32'(ScuState), 32'd0);
        ScuEn = 1'b1; tick();

        // Re-arm from a fresh reset so the fire count starts at zero
        rst = 1'b1; #1; rst = 1'b0; tick();
        RegRearm = 1'b1; RegDelay = 8'd0; RegDuration = 8'd2; RegCtrlMode = 2'b00;
        RegCtrlVal = 4'b0000; RegCtrlMask = 4'b1111; s_in = 4'b1111;
        trigger = 1'b1; tick(); #1;
        chk("rearm_t1", 32'(ScuState), 32'd3);
        tick(); trigger = 1'b0; #1;
        chk("rearm_t2", 32'(ScuState), 32'd3);
        tick(); #1; chk("rearm_t3", 32'(ScuState), 32'd1);
        tick(); tick(); trigger = 1'b1;
        tick(); trigger = 1'b0; #1; chk("rearm_t6", 32'(ScuState), 32'd3);
        tick(); #1; chk("rearm_t7", 32'(ScuState), 32'd3);
        tick(); #1; chk("rearm_t8", 32'(ScuState), 32'd1);
        chk("rearm_fire", 32'(ScuFireCnt), 32'd2);
        chk("model_fire2", 32'(m_fire), 32'd2);

        // Asynchronous reset in the second cycle of a 5-cycle override
        RegRearm = 1'b0; RegDuration = 8'd5; s_in = 4'b0101;
        trigger = 1'b1; tick(); trigger = 1'b0;
        tick(); #1;
        chk("arst_pre", 32'(s_out), 32'(4'b0000));
        rst = 1'b1; #1;
        chk("arst_s_out", 32'(s_out), 32'(4'b0101));
        chk("arst_state", 32'(ScuState), 32'd0);
        chk("arst_fire", 32'(ScuFireCnt), 32'd0);
        tick(); rst = 1'b0; tick(); #1;
        chk("arst_armed", 32'(ScuState), 32'd1);
        trigger = 1'b1; tick(); trigger = 1'b0; #1;
        chk("arst_refire", 32'(ScuState), 32'd3);
        chk("arst_refire_cnt", 32'(ScuFireCnt), 32'd1);
        reenable();

        // Delay of 1 followed by fire-count saturation
        RegDelay = 8'd1; RegDuration = 8'd1; RegRearm = 1'b1;
        trigger = 1'b1; tick(); #1;
        chk("dly1_t1", 32'(ScuState), 32'd2);
        tick(); #1;
        chk("dly1_t2", 32'(ScuState), 32'd3);
        RegDelay = 8'd0;
        repeat (600) tick();
        trigger = 1'b0; tick(); tick(); #1;
        chk("sat_fire", 32'(ScuFireCnt), 32'd255);
        chk("model_sat", 32'(m_fire), 32'd255);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
